// File: rtl/nrs_pkg.sv
// Shared definitions for the NRS sequencer/combiner.
// Holds the default Gold-sequence timing constants, the FSM state encoding
// and the QPSK sign convention used when packing c(n) bits into sign pairs.
package nrs_pkg;

    // Gold fast-forward length.
    localparam int NC_DEF      = 1600;
    // Extra c bits thrown away before the first pair (2*m', m' = 109).
    localparam int SKIP_DEF    = 218;
    // QPSK pairs produced per start.
    localparam int NUM_SYM_DEF = 2;
    // Counter width; holds NC+SKIP-1 and 2*NUM_SYM.
    localparam int CNT_W_DEF   = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_WARM = 2'd2,
        ST_GEN  = 2'd3
    } nrs_state_t;

    // Sign bit value that selects -1/sqrt2 (0 selects +1/sqrt2).
    localparam logic QPSK_NEG = 1'b1;

    // Maps a Gold bit c(n) to the emitted sign bit: c=1 -> negative amplitude.
    function automatic logic qpsk_sign(input logic c);
        return c ? QPSK_NEG : ~QPSK_NEG;
    endfunction

endpackage

// File: rtl/nrs_pair_buf.sv
// Pair buffer for the NRS sequencer.
// Collects the even Gold bit into c_even, and on the following odd bit loads
// the (I, Q) sign pair into the output register and raises nrs_valid.
// Handshake: a pair transfers on a rising clk edge where nrs_valid && nrs_ready;
// nrs_i/nrs_q are held stable while nrs_valid && !nrs_ready.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   shift        the LFSRs shift this cycle; bit_val is a real c(n) bit
//   bit_odd      the bit being consumed has odd index within the pair stream
//   bit_val      c(n) = x1(n) ^ x2(n), pre-shift value
//   nrs_ready    consumer ready
//   nrs_i/nrs_q  output sign pair
//   nrs_valid    output pair valid
module nrs_pair_buf
    import nrs_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic shift,
    input  logic bit_odd,
    input  logic bit_val,
    input  logic nrs_ready,
    output logic nrs_i,
    output logic nrs_q,
    output logic nrs_valid
);

    logic c_even;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_even    <= 1'b0;
            nrs_i     <= 1'b0;
            nrs_q     <= 1'b0;
            nrs_valid <= 1'b0;
        end else begin
            if (shift && !bit_odd) begin
                c_even <= bit_val;
            end
            // The controller never shifts an odd bit while a pair is stalled,
            // so loading here cannot overwrite an unaccepted pair.
            if (shift && bit_odd) begin
                nrs_i     <= qpsk_sign(c_even);
                nrs_q     <= qpsk_sign(bit_val);
                nrs_valid <= 1'b1;
            end else if (nrs_valid && nrs_ready) begin
                nrs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/nrs_seq_ctrl.sv
// NRS sequencer/combiner sitting right after the x1/x2 Gold LFSRs.
// Reloads and fast-forwards both LFSRs (outputs masked), then combines
// c(n) = x1(n) ^ x2(n) into QPSK sign pairs delivered over valid/ready.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        1-cycle pulse, accepted only when idle; captures c_init
//   c_init       x2 seed
//   x1_bit       x1 LFSR output (gated by lfsr_out in the parent)
//   x2_bit       x2 LFSR output (gated by lfsr_out in the parent)
//   lfsr_init    reload both LFSR seeds
//   lfsr_en      shift both LFSRs one step
//   lfsr_out     ungate LFSR output bits
//   x2_seed      registered c_init
//   nrs_i/nrs_q  sign pair (c(2m), c(2m+1)); 1 means -1/sqrt2
//   nrs_valid    pair valid
//   nrs_ready    consumer ready
//   busy         high from accepted start until last pair accepted
//   fsm_state    current controller state (debug)
module nrs_seq_ctrl
    import nrs_pkg::*;
#(
    parameter int NC      = NC_DEF,
    parameter int SKIP    = SKIP_DEF,
    parameter int NUM_SYM = NUM_SYM_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [30:0] c_init,
    input  logic        x1_bit,
    input  logic        x2_bit,
    output logic        lfsr_init,
    output logic        lfsr_en,
    output logic        lfsr_out,
    output logic [30:0] x2_seed,
    output logic        nrs_i,
    output logic        nrs_q,
    output logic        nrs_valid,
    input  logic        nrs_ready,
    output logic        busy,
    output logic [1:0]  fsm_state
);

    localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(NC + SKIP - 1);
    localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(2 * NUM_SYM);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    nrs_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             gen_shift;
    logic             bit_odd;

    // In GEN, cnt counts shifts already done, so its LSB is the parity of
    // the bit currently presented by the LFSRs.
    assign bit_odd   = cnt[0];
    assign fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            x2_seed <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && start) begin
                x2_seed <= c_init;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lfsr_init = 1'b0;
        lfsr_en   = 1'b0;
        lfsr_out  = 1'b0;
        busy      = 1'b1;
        gen_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                busy    = 1'b0;
                cnt_nxt = '0;
                if (start) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                lfsr_init = 1'b1;
                cnt_nxt   = '0;
                state_nxt = ST_WARM;
            end
            ST_WARM: begin
                lfsr_en = 1'b1;
                if (cnt == WARM_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_GEN;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_GEN: begin
                lfsr_out = 1'b1;
                if (cnt != GEN_LAST) begin
                    // An odd bit would complete a pair; hold it while the
                    // previous pair is still waiting. Even bits go into c_even.
                    if (!(bit_odd && nrs_valid && !nrs_ready)) begin
                        lfsr_en   = 1'b1;
                        gen_shift = 1'b1;
                        cnt_nxt   = cnt + CNT_ONE;
                    end
                end else if (nrs_valid && nrs_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    nrs_pair_buf u_pair_buf (
        .clk       (clk),
        .rst       (rst),
        .shift     (gen_shift),
        .bit_odd   (bit_odd),
        .bit_val   (x1_bit ^ x2_bit),
        .nrs_ready (nrs_ready),
        .nrs_i     (nrs_i),
        .nrs_q     (nrs_q),
        .nrs_valid (nrs_valid)
    );

endmodule

// File: tb/tb_nrs_seq_ctrl.sv
// Bench for nrs_seq_ctrl: plays the parent x1/x2 LFSRs, drives start/ready,
// and checks pairs against a Gold-sequence model built from the 36.211 recursions.
module tb_nrs_seq_ctrl;
    import nrs_pkg::*;

    localparam int LAT     = 1822;  // start cycle -> first nrs_valid
    localparam int SEQ_LEN = NC_DEF + SKIP_DEF + 2 * NUM_SYM_DEF;
    localparam int TMO     = 4000;

    logic        clk;
    logic        rst;
    logic        start;
    logic [30:0] c_init;
    logic        x1_bit;
    logic        x2_bit;
    logic        lfsr_init;
    logic        lfsr_en;
    logic        lfsr_out;
    logic [30:0] x2_seed;
    logic        nrs_i;
    logic        nrs_q;
    logic        nrs_valid;
    logic        nrs_ready;
    logic        busy;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_pairs  = 0;
    int n_init   = 0;

    logic [1:0] exp_q[$];
    logic [1:0] e_pair;
    logic       prev_stall;
    logic       prev_i;
    logic       prev_q;

    bit m_x1[SEQ_LEN];
    bit m_x2[SEQ_LEN];

    nrs_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c_init    (c_init),
        .x1_bit    (x1_bit),
        .x2_bit    (x2_bit),
        .lfsr_init (lfsr_init),
        .lfsr_en   (lfsr_en),
        .lfsr_out  (lfsr_out),
        .x2_seed   (x2_seed),
        .nrs_i     (nrs_i),
        .nrs_q     (nrs_q),
        .nrs_valid (nrs_valid),
        .nrs_ready (nrs_ready),
        .busy      (busy),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- parent LFSRs ----------------
    logic [30:0] x1_r = '0;
    logic [30:0] x2_r = '0;

    always @(posedge clk) begin
        if (lfsr_init) begin
            x1_r <= 31'd1;
            x2_r <= x2_seed;
        end else if (lfsr_en) begin
            x1_r <= {x1_r[3] ^ x1_r[0], x1_r[30:1]};
            x2_r <= {x2_r[3] ^ x2_r[2] ^ x2_r[1] ^ x2_r[0], x2_r[30:1]};
        end
    end

    assign x1_bit = lfsr_out & x1_r[0];
    assign x2_bit = lfsr_out & x2_r[0];

    // ---------------- model ----------------
    task automatic build_model(input logic [30:0] seed);
        for (int i = 0; i < 31; i++) begin
            m_x1[i] = (i == 0);
            m_x2[i] = seed[i];
        end
        for (int n = 31; n < SEQ_LEN; n++) begin
            m_x1[n] = m_x1[n-28] ^ m_x1[n-31];
            m_x2[n] = m_x2[n-28] ^ m_x2[n-29] ^ m_x2[n-30] ^ m_x2[n-31];
        end
    endtask

    function automatic logic c_at(input int n);
        return m_x1[n + NC_DEF] ^ m_x2[n + NC_DEF];
    endfunction

    task automatic push_expected(input logic [30:0] seed);
        build_model(seed);
        for (int m = 0; m < NUM_SYM_DEF; m++) begin
            exp_q.push_back({c_at(SKIP_DEF + 2 * m), c_at(SKIP_DEF + 2 * m + 1)});
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (!busy) begin
                check("idle_quiet", {60'd0, lfsr_en, lfsr_out, lfsr_init, nrs_valid}, 64'd0);
            end
            if (prev_stall) begin
                check("stall_hold", {61'd0, nrs_valid, nrs_i, nrs_q}, {61'd0, 1'b1, prev_i, prev_q});
            end
            if (nrs_valid && nrs_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pair_unexpected: got pair %0b%0b, expected none", nrs_i, nrs_q);
                end else begin
                    e_pair = exp_q.pop_front();
                    check("pair", {62'd0, nrs_i, nrs_q}, {62'd0, e_pair});
                end
                n_pairs <= n_pairs + 1;
            end
            if (lfsr_init) n_init <= n_init + 1;
            prev_stall <= nrs_valid && !nrs_ready;
            prev_i     <= nrs_i;
            prev_q     <= nrs_q;
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [63:0] all_outs();
        return {26'd0, x2_seed, nrs_i, nrs_q, nrs_valid, busy, lfsr_init, lfsr_en, lfsr_out};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        nrs_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", all_outs(), 64'd0);
        exp_q.delete();
        rst = 1'b0;
    endtask

    // Call at #1 after a posedge.
    task automatic start_now(input logic [30:0] seed, input bit accept, output int k);
        start = 1'b1;
        c_init = seed;
        k = cyc;
        if (accept) push_expected(seed);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_start(input logic [30:0] seed, input bit accept, output int k);
        @(posedge clk);
        #1;
        start_now(seed, accept, k);
    endtask

    task automatic wait_cycle(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_first_valid(input int k, input string name);
        int t = 0;
        @(negedge clk);
        while (!nrs_valid && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (!nrs_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no nrs_valid within %0d cycles", name, TMO);
        end else begin
            check(name, 64'(cyc - k), 64'(LAT));
        end
    endtask

    task automatic wait_idle(input string name, output int c);
        int t = 0;
        @(negedge clk);
        while (busy && t < TMO) begin
            @(negedge clk);
            t++;
        end
        c = cyc;
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: busy still high after %0d cycles", name, TMO);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int k, k2, c, snap;
        rst = 1'b1;
        start = 1'b0;
        c_init = '0;
        nrs_ready = 1'b1;
        do_reset();

        // Model pins, worked out by hand from the recursions.
        build_model(31'h0);
        check("pin_x1_31", 64'(m_x1[31]), 64'd1);
        check("pin_x1_32", 64'(m_x1[32]), 64'd0);
        check("pin_x1_59", 64'(m_x1[59]), 64'd1);
        check("pin_x1_62", 64'(m_x1[62]), 64'd1);
        check("pin_x2_zero", 64'({m_x2[1818], m_x2[1819], m_x2[1820], m_x2[1821]}), 64'd0);
        build_model(31'h0000_1234);
        check("pin_x2_31", 64'(m_x2[31]), 64'd1);
        check("pin_x2_32", 64'(m_x2[32]), 64'd0);

        // 1: c_init = 0, ready high; latency and 2-cycle pair spacing.
        pulse_start(31'h0, 1'b1, k);
        wait_first_valid(k, "s1_latency");
        @(negedge clk);
        check("s1_gap_low", 64'(nrs_valid), 64'd0);
        @(negedge clk);
        check("s1_gap_high", 64'(nrs_valid), 64'd1);
        wait_idle("s1_idle", c);
        check("s1_busy_fall", 64'(c - k), 64'(LAT + 3));
        check("s1_drain", 64'(exp_q.size()), 64'd0);

        // 2: cell-style seed.
        pulse_start(31'h0000_1234, 1'b1, k);
        check("s2_seed", 64'(x2_seed), 64'h1234);
        check("s2_busy", 64'(busy), 64'd1);
        wait_first_valid(k, "s2_latency");
        wait_idle("s2_idle", c);
        check("s2_drain", 64'(exp_q.size()), 64'd0);

        // 3: 10-cycle stall at first valid.
        pulse_start(31'h0000_1234, 1'b1, k);
        wait_cycle(k + LAT);
        nrs_ready = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("s3_valid", 64'(nrs_valid), 64'd1);
            check("s3_lfsr_en", 64'(lfsr_en), (j == 0) ? 64'd1 : 64'd0);
            @(posedge clk);
            #1;
        end
        nrs_ready = 1'b1;
        wait_idle("s3_idle", c);
        check("s3_drain", 64'(exp_q.size()), 64'd0);

        // 4: start pulsed mid-WARM is ignored.
        pulse_start(31'h0000_1234, 1'b1, k);
        wait_cycle(k + 500);
        start_now(31'h7fff_0001, 1'b0, k2);
        check("s4_seed_kept", 64'(x2_seed), 64'h1234);
        wait_first_valid(k, "s4_latency");
        wait_idle("s4_idle", c);
        check("s4_drain", 64'(exp_q.size()), 64'd0);

        // 5: reset during GEN after one pair, then full rerun.
        snap = n_pairs;
        pulse_start(31'h0000_1234, 1'b1, k);
        wait_first_valid(k, "s5_latency");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("s5_reset_outputs", all_outs(), 64'd0);
        check("s5_one_pair", 64'(n_pairs - snap), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_start(31'h0000_1234, 1'b1, k);
        wait_first_valid(k, "s5_rerun_latency");
        wait_idle("s5_idle", c);
        check("s5_drain", 64'(exp_q.size()), 64'd0);

        // 6: back-to-back starts, second in the first idle cycle.
        snap = n_init;
        pulse_start(31'h0000_1234, 1'b1, k);
        wait_cycle(k + LAT + 3);
        start_now(31'h0000_1234, 1'b1, k2);
        wait_first_valid(k2, "s6_latency");
        wait_idle("s6_idle", c);
        check("s6_init_pulses", 64'(n_init - snap), 64'd2);
        check("s6_drain", 64'(exp_q.size()), 64'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
